// File: rtl/mul32_seq.sv
// ---------------------------------------------------------------------------
// mul32_seq -- sequential 32x32 -> 64 multiplier built on one 18x18 DSP block.
//
// An operand pair is accepted over a valid/ready handshake. Four 16x16 partial
// products are issued to a single mult18x18 instance and summed into a 64-bit
// accumulator. The product is then held on a valid/ready output handshake.
// Unsigned build latency is 5 cycles from accept to out_valid. The minimum
// initiation interval is 7 cycles.
//
// Optional feature: define MUL32_SIGNED_EN to add the `sgn` input and the FIX
// state. This gives signed multiplication, with 6-cycle latency and an
// initiation interval of 8.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset (also resets the DSP)
//   in_valid  in   1   a/b valid
//   in_ready  out  1   ready to accept (IDLE only)
//   a, b      in   32  multiplicand / multiplier
//   sgn       in   1   signed operation (MUL32_SIGNED_EN builds only)
//   out_valid out  1   p holds a completed product
//   out_ready in   1   consumer accepts p
//   p         out  64  product
//   busy      out  1   any state other than IDLE
// ---------------------------------------------------------------------------

// Registered 18x18 unsigned multiplier. O only updates when en is high.
module mult18x18 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [17:0] a,
  input  logic [17:0] b,
  output logic [35:0] o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o <= '0;
    end else if (en) begin
      o <= a * b;
    end
  end

endmodule

module mul32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MUL32_SIGNED_EN
  input  logic        sgn,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] p,
  output logic        busy
);

`ifdef MUL32_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;

  logic        mult_en;
  logic [17:0] mult_a;
  logic [17:0] mult_b;
  logic [35:0] mult_o;
  logic [63:0] pp_ext;
  logic [63:0] pp_shift;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // O[35:32] is always zero for zero-extended 16-bit halves.
  logic        mult_hi_unused;
  assign mult_hi_unused = |mult_o[35:32];

`ifdef MUL32_SIGNED_EN
  logic        sign_q, sign_d;

  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    // -2^31 maps to 32'h8000_0000, which reads correctly as unsigned 2^31.
    mag32 = v[31] ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [63:0] neg64(input logic signed [63:0] v);
    neg64 = 64'(-v);
  endfunction

  assign a_mag = sgn ? mag32(a) : a;
  assign b_mag = sgn ? mag32(b) : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // Issue select: cnt 0..3 -> aL*bL, aL*bH, aH*bL, aH*bH.
  assign mult_en = (state_q == RUN) && (cnt_q < 3'd4);
  assign mult_a  = {2'b00, cnt_q[1] ? a_q[31:16] : a_q[15:0]};
  assign mult_b  = {2'b00, cnt_q[0] ? b_q[31:16] : b_q[15:0]};

  mult18x18 u_mult (
    .clk (clk),
    .rst (rst),
    .en  (mult_en),
    .a   (mult_a),
    .b   (mult_b),
    .o   (mult_o)
  );

  // The product returned while cnt=k belongs to pp[k-1].
  assign pp_ext = {32'd0, mult_o[31:0]};
  always_comb begin
    case (cnt_q)
      3'd1:         pp_shift = pp_ext;
      3'd2, 3'd3:   pp_shift = pp_ext << 16;
      default:      pp_shift = pp_ext << 32;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
`ifdef MUL32_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a_mag;
          b_d     = b_mag;
          acc_d   = '0;
          cnt_d   = 3'd0;
          state_d = RUN;
`ifdef MUL32_SIGNED_EN
          sign_d  = sgn & (a[31] ^ b[31]);
`endif
        end
      end
      RUN: begin
        if (cnt_q != 3'd0) begin
          acc_d = acc_q + pp_shift;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          cnt_d   = 3'd0;
`ifdef MUL32_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MUL32_SIGNED_EN
      FIX: begin
        if (sign_q) begin
          acc_d = neg64(acc_q);
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered off the next state, so they line up with it.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MUL32_SIGNED_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
`ifdef MUL32_SIGNED_EN
      sign_q      <= sign_d;
`endif
    end
  end

  // Operand registers are only ever read after an accept reloads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign p         = acc_q;

endmodule

// File: tb/tb_mul32_seq.sv
module tb_mul32_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;
  logic        busy;
`ifdef MUL32_SIGNED_EN
  logic        sgn;
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  mul32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef MUL32_SIGNED_EN
    .sgn       (sgn),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with the DSP enable high (sampled mid-cycle).
  always @(negedge clk) if (dut.u_mult.en) en_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction with out_ready high: latency, value, and release to IDLE.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] pe);
    int lat;
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_p"}, p, pe);
    chk({tag, "_inrdy_lo"}, 64'(in_ready), 64'd0);
    step();
    chk({tag, "_ovld_lo"}, 64'(out_valid), 64'd0);
    chk({tag, "_inrdy_hi"}, 64'(in_ready), 64'd1);
  endtask

  logic [31:0] qa [3];
  logic [31:0] qb [3];
  logic [63:0] qp [3];

  initial begin
    int lat;
    int n_in;
    int n_out;
    int both;
    int cyc;
    logic acc_now;
    logic stable;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
`ifdef MUL32_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (3) step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p", p, 64'd0);
    rst = 1'b0;
    step();

    run_op("small", 32'd3, 32'd5, 64'd15);

    en_cnt = 0;
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    chk("max_en_cycles", 64'(en_cnt), 64'd4);

    // Output stall with in_valid held high.
    in_valid = 1'b1; a = 32'h0001_0000; b = 32'h0001_0000; out_ready = 1'b0;
    step();
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("stall_lat", 64'(lat), 64'(LAT));
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (p !== 64'h0000_0001_0000_0000 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
      step();
    end
    chk("stall_stable", 64'(stable), 64'd1);
    chk("stall_p", p, 64'h0000_0001_0000_0000);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("stall_release", 64'(in_ready), 64'd1);

    // Reset while RUN is at cnt=2.
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    step();
    step();
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_p", p, 64'd0);
    #1 rst = 1'b0;
    step();
    run_op("after_rst", 32'd7, 32'd6, 64'd42);

`ifdef MUL32_SIGNED_EN
    sgn = 1'b1;
    run_op("s_neg", 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("s_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    sgn = 1'b0;
`endif

    // Back-to-back: three queued pairs, in_valid held high.
    qa[0] = 32'd2;          qb[0] = 32'd3;          qp[0] = 64'd6;
    qa[1] = 32'h1234_5678;  qb[1] = 32'h10;         qp[1] = 64'h1_2345_6780;
    qa[2] = 32'hFFFF_FFFF;  qb[2] = 32'd2;          qp[2] = 64'h1_FFFF_FFFE;
    n_in = 0; n_out = 0; both = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = qa[0]; b = qb[0];
    while (n_out < 3 && cyc < 200) begin
      acc_now = in_valid & in_ready;
      step();
      cyc++;
      if (acc_now) begin
        n_in++;
        if (n_in < 3) begin
          a = qa[n_in]; b = qb[n_in];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_ready && out_valid) both++;
      if (out_valid) begin
        chk($sformatf("b2b_p%0d", n_out), p, qp[n_out]);
        n_out++;
      end
    end
    chk("b2b_results", 64'(n_out), 64'd3);
    chk("b2b_accepts", 64'(n_in), 64'd3);
    chk("b2b_never_both", 64'(both), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
